// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter slice: default width,
// direction encoding and a helper giving the all-ones count for a width.
package up_down_counter_pkg;

    // Default counter width in bits
    localparam int DEFAULT_WIDTH = 4;

    // Direction encoding on the up_down input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Largest representable count for a given width (2^width - 1).
    // Built by shifting ones in so width=64 does not overflow.
    function automatic logic [63:0] max_value(input int width);
        logic [63:0] result;
        result = '0;
        for (int i = 0; i < width && i < 64; i++) begin
            result[i] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/up_down_counter_next.sv
// Combinational next-count logic for up_down_counter.
// Default build wraps modulo 2^WIDTH; with UP_DOWN_COUNTER_SAT_EN defined
// the count holds at the all-ones value going up and at zero going down.
module up_down_counter_next
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_value(WIDTH));
    localparam logic [WIDTH-1:0] MIN_COUNT = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    // Carry/borrow are dropped by the WIDTH-bit result, giving modulo wrap
    assign count_inc = count + ONE;
    assign count_dec = count - ONE;

    // Select the step direction and apply the end-of-range policy
    always_comb begin
        count_next = count;
        if (up_down == DIR_UP) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            count_next = (count == MAX_COUNT) ? count : count_inc;
`else
            count_next = count_inc;
`endif
        end else begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            count_next = (count == MIN_COUNT) ? count : count_dec;
`else
            count_next = count_dec;
`endif
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Synchronous binary up/down counter with direction select and
// synchronous active-high reset. Steps once per clock edge, no enable.
// Optional macro UP_DOWN_COUNTER_SAT_EN selects saturating instead of
// wrap-around counting (handled inside up_down_counter_next).
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter
);

    logic [WIDTH-1:0] counter_reg;
    logic [WIDTH-1:0] counter_next;

    up_down_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (counter_reg),
        .up_down    (up_down),
        .count_next (counter_next)
    );

    // Count register; reset takes priority over the direction input
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_reg <= RESET_VALUE;
        end else begin
            counter_reg <= counter_next;
        end
    end

    // Output comes straight from the register, no combinational path
    assign counter = counter_reg;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (WIDTH=4, RESET_VALUE=0).
// Honors UP_DOWN_COUNTER_SAT_EN for expected values.
`timescale 1ns/1ps
module tb_up_down_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         up_down;
    logic [W-1:0] counter;

    up_down_counter #(
        .WIDTH       (W),
        .RESET_VALUE (4'd0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .up_down (up_down),
        .counter (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;

    // Behavioural model: plain integer arithmetic on the spec rules
    int  model_val   = 0;
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            model_val   <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            if (up_down) model_val <= (model_val >= MAXV) ? MAXV : model_val + 1;
            else         model_val <= (model_val <= 0) ? 0 : model_val - 1;
`else
            if (up_down) model_val <= (model_val + 1) % (MAXV + 1);
            else         model_val <= (model_val + MAXV) % (MAXV + 1);
`endif
        end
    end

    // Hand-computed literal expectation for the current cycle
    int    lit_exp   = 0;
    bit    lit_valid = 1'b0;
    string lit_name  = "";

    // Single compare process: model check every meaningful cycle plus literals
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (counter !== W'(model_val)) begin
                errors++;
                $display("FAIL model t=%0t counter=%0d expected=%0d", $time, counter, model_val);
            end
        end
        if (lit_valid) begin
            checks++;
            if (counter !== W'(lit_exp)) begin
                errors++;
                $display("FAIL %s t=%0t counter=%0d expected=%0d", lit_name, $time, counter, lit_exp);
            end else begin
                $display("ok   %s reset=%0b up_down=%0b counter=%0d", lit_name, reset, up_down, counter);
            end
        end
    end

    // Apply inputs for one edge, then post the literal expectation
    task automatic step(input logic r, input logic u, input int e, input string name);
        reset   = r;
        up_down = u;
        @(posedge clk);
        #1;
        lit_exp   = e;
        lit_name  = name;
        lit_valid = 1'b1;
        @(negedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        up_down = 1'b1;

        // Reset for two edges, then count up
        step(1'b1, 1'b1, 0, "reset0");
        step(1'b1, 1'b1, 0, "reset1");
        step(1'b0, 1'b1, 1, "up_after_reset");
        step(1'b0, 1'b1, 2, "up_after_reset");
        step(1'b0, 1'b1, 3, "up_after_reset");

        // Down from reset value
        step(1'b1, 1'b0, 0, "reset_dn");
`ifdef UP_DOWN_COUNTER_SAT_EN
        step(1'b0, 1'b0, 0, "down_sat");
        step(1'b0, 1'b0, 0, "down_sat");
        step(1'b0, 1'b0, 0, "down_sat");
`else
        step(1'b0, 1'b0, 15, "down_wrap");
        step(1'b0, 1'b0, 14, "down_wrap");
        step(1'b0, 1'b0, 13, "down_wrap");
`endif

        // Up across the top of the range: 1..15 then wrap (or hold)
        step(1'b1, 1'b1, 0, "reset_up");
        for (int i = 1; i <= 16; i++) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            step(1'b0, 1'b1, (i > 15) ? 15 : i, "up_sat");
`else
            step(1'b0, 1'b1, i % 16, "up_wrap");
`endif
        end

        // Direction switch with no pause cycle
        step(1'b1, 1'b1, 0, "reset_sw");
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, i, "sw_up");
        step(1'b0, 1'b0, 4, "sw_down");
        step(1'b0, 1'b0, 3, "sw_down");
        step(1'b0, 1'b1, 4, "sw_up_again");

        // Mid-count reset at 9, reset wins over up_down=1
        for (int i = 5; i <= 9; i++) step(1'b0, 1'b1, i, "to_nine");
        step(1'b1, 1'b1, 0, "mid_reset");
        step(1'b0, 1'b1, 1, "after_mid_reset");

        // Five down edges from reset value
        step(1'b1, 1'b0, 0, "reset_low");
        for (int i = 1; i <= 5; i++) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            step(1'b0, 1'b0, 0, "sat_low");
`else
            step(1'b0, 1'b0, 16 - i, "wrap_low");
`endif
        end

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
